// File: rtl/proc_io_port.sv
// proc_io_port: device-side I/O port with input FIFO, output holding register and interrupt.
// Define PROC_IO_INT_EN to build the interrupt FSM; otherwise interrupt is tied low.
module proc_io_port #(
  parameter int DATA_W     = 16,
  parameter int IN_DEPTH   = 4,
  parameter int INT_THRESH = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         dev_in_data,
  input  logic                      dev_in_valid,
  output logic                      dev_in_ready,
  output logic [DATA_W-1:0]         cpu_data_in,
  input  logic                      cpu_rd,
  input  logic [DATA_W-1:0]         cpu_data_out,
  input  logic                      cpu_wr,
  output logic                      cpu_wr_busy,
  output logic [DATA_W-1:0]         dev_out_data,
  output logic                      dev_out_valid,
  input  logic                      dev_out_ready,
  output logic                      interrupt,
  input  logic                      int_ack,
  output logic [$clog2(IN_DEPTH):0] in_count,
  output logic [1:0]                err
);

  localparam int AW = $clog2(IN_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IN_DEPTH);

  typedef enum logic {OUT_IDLE, OUT_FULL} out_st_e;

  logic [DATA_W-1:0] mem_q [IN_DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic              full, empty, push, pop;
  out_st_e           out_st_q;
  logic [DATA_W-1:0] out_data_q;

  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign push  = dev_in_valid && !full;
  assign pop   = cpu_rd && !empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (cpu_rd && empty) err_d[0] = 1'b1;
    if (out_st_q == OUT_FULL && cpu_wr && !dev_out_ready)
      err_d[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks the head to zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dev_in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_st_q   <= OUT_IDLE;
      out_data_q <= '0;
    end else begin
      unique case (out_st_q)
        OUT_IDLE: begin
          if (cpu_wr) begin
            out_data_q <= cpu_data_out;
            out_st_q   <= OUT_FULL;
          end
        end
        OUT_FULL: begin
          if (dev_out_ready) begin
            if (cpu_wr) out_data_q <= cpu_data_out;
            else        out_st_q   <= OUT_IDLE;
          end
        end
      endcase
    end
  end

  assign dev_in_ready  = !full;
  assign cpu_data_in   = empty ? '0 : mem_q[rd_ptr_q];
  assign in_count      = cnt_q;
  assign err           = err_q;
  assign dev_out_valid = (out_st_q == OUT_FULL);
  assign dev_out_data  = out_data_q;
  assign cpu_wr_busy   = (out_st_q == OUT_FULL) && !dev_out_ready;

`ifdef PROC_IO_INT_EN
  localparam logic [CW-1:0] THRESH_C = CW'(INT_THRESH);

  typedef enum logic [1:0] {INT_IDLE, INT_PEND, INT_WAIT} int_st_e;

  int_st_e int_st_q;
  logic    irq_q;

  // One interrupt per fill episode: re-arm only once occupancy drops below threshold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_st_q <= INT_IDLE;
      irq_q    <= 1'b0;
    end else begin
      unique case (int_st_q)
        INT_IDLE: begin
          if (cnt_q >= THRESH_C) begin
            int_st_q <= INT_PEND;
            irq_q    <= 1'b1;
          end
        end
        INT_PEND: begin
          if (int_ack) begin
            int_st_q <= INT_WAIT;
            irq_q    <= 1'b0;
          end
        end
        INT_WAIT: begin
          if (cnt_q < THRESH_C) int_st_q <= INT_IDLE;
        end
        default: begin
          int_st_q <= INT_IDLE;
          irq_q    <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt = irq_q;
`else
  localparam int UNUSED_THRESH = INT_THRESH;
  logic unused_ack;
  assign unused_ack = int_ack;
  assign interrupt  = 1'b0;
`endif

endmodule

// File: tb/tb_proc_io_port.sv
// tb_proc_io_port: random and directed stimulus against a queue-based reference model.
// Honours PROC_IO_INT_EN the same way the design does.
module tb_proc_io_port;

  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int TH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] dev_in_data = '0;
  logic          dev_in_valid = 1'b0;
  logic          dev_in_ready;
  logic [DW-1:0] cpu_data_in;
  logic          cpu_rd = 1'b0;
  logic [DW-1:0] cpu_data_out = '0;
  logic          cpu_wr = 1'b0;
  logic          cpu_wr_busy;
  logic [DW-1:0] dev_out_data;
  logic          dev_out_valid;
  logic          dev_out_ready = 1'b0;
  logic          interrupt;
  logic          int_ack = 1'b0;
  logic [2:0]    in_count;
  logic [1:0]    err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  proc_io_port #(
    .DATA_W(DW), .IN_DEPTH(DEPTH), .INT_THRESH(TH)
  ) dut (
    .clk(clk), .reset(reset),
    .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid),
    .dev_in_ready(dev_in_ready), .cpu_data_in(cpu_data_in),
    .cpu_rd(cpu_rd), .cpu_data_out(cpu_data_out),
    .cpu_wr(cpu_wr), .cpu_wr_busy(cpu_wr_busy),
    .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid),
    .dev_out_ready(dev_out_ready), .interrupt(interrupt),
    .int_ack(int_ack), .in_count(in_count), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word queue, an output slot and an interrupt episode flag.
  logic [DW-1:0] q[$];
  bit            m_ov;
  logic [DW-1:0] m_od;
  bit [1:0]      m_err;
  bit            m_irq;
  bit            m_served;

  always @(posedge clk or negedge reset) begin : model
    int occ;
    if (!reset) begin
      q.delete();
      m_ov = 0; m_od = '0; m_err = '0;
      m_irq = 0; m_served = 0;
    end else begin
      occ = q.size();
      if (cpu_rd && occ == 0) m_err[0] = 1;
      if (cpu_rd && occ > 0) void'(q.pop_front());
      if (dev_in_valid && occ < DEPTH) q.push_back(dev_in_data);
      if (!m_ov) begin
        if (cpu_wr) begin m_ov = 1; m_od = cpu_data_out; end
      end else if (dev_out_ready) begin
        if (cpu_wr) m_od = cpu_data_out;
        else        m_ov = 0;
      end else if (cpu_wr) begin
        m_err[1] = 1;
      end
`ifdef PROC_IO_INT_EN
      if (m_irq) begin
        if (int_ack) begin m_irq = 0; m_served = 1; end
      end else if (m_served) begin
        if (occ < TH) m_served = 0;
      end else if (occ >= TH) begin
        m_irq = 1;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_count", in_count, q.size());
      chk("dev_in_ready", dev_in_ready, q.size() < DEPTH);
      chk("cpu_data_in", cpu_data_in, q.size() > 0 ? q[0] : 16'h0);
      chk("dev_out_valid", dev_out_valid, m_ov);
      if (m_ov) chk("dev_out_data", dev_out_data, m_od);
      chk("cpu_wr_busy", cpu_wr_busy, m_ov && !dev_out_ready);
      chk("interrupt", interrupt, m_irq);
      chk("err", err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    dev_in_valid = 0;
    cpu_rd = 0;
    cpu_wr = 0;
    int_ack = 0;
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    @(posedge clk);
    #1;
    reset = 1;
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    dev_in_valid = 1; dev_in_data = d;
    tick();
  endtask

  task automatic rd();
    cpu_rd = 1;
    tick();
  endtask

  logic [DW-1:0] exp_words [4];
  bit exp_irq;

  initial begin
    exp_words[0] = 16'h2222; exp_words[1] = 16'h3333;
    exp_words[2] = 16'h4444; exp_words[3] = 16'h0000;
    chk_en = 1;

    // Reset held with random inputs
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      dev_in_valid = 1'($urandom); dev_in_data = 16'($urandom);
      cpu_rd = 1'($urandom); cpu_wr = 1'($urandom);
      cpu_data_out = 16'($urandom); dev_out_ready = 1'($urandom);
      int_ack = 1'($urandom);
      @(posedge clk); #1;
    end
    dev_in_valid = 0; cpu_rd = 0; cpu_wr = 0; int_ack = 0;
    dev_out_ready = 0;
    reset = 1;
    #1;
    chk("rst cpu_data_in", cpu_data_in, 16'h0);
    chk("rst in_count", in_count, 0);
    chk("rst dev_in_ready", dev_in_ready, 1);
    chk("rst dev_out_valid", dev_out_valid, 0);
    chk("rst dev_out_data", dev_out_data, 16'h0);
    chk("rst cpu_wr_busy", cpu_wr_busy, 0);
    chk("rst interrupt", interrupt, 0);
    chk("rst err", err, 0);

    // Fill and drain
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    chk("fill count", in_count, 4);
    chk("fill ready", dev_in_ready, 0);
    chk("fill head", cpu_data_in, 16'h1111);
    push(16'h5555);
    chk("overfill count", in_count, 4);
    for (int i = 0; i < 4; i++) begin
      rd();
      chk("drain head", cpu_data_in, exp_words[i]);
    end
    chk("drain err", err, 2'b00);
    rd();
    chk("underflow err", err, 2'b01);

    // Pointer wrap: one word primed, then push+pop each cycle
    do_reset();
    push(16'h0001);
    for (int i = 2; i <= 10; i++) begin
      chk("wrap head before", cpu_data_in, i - 1);
      cpu_rd = 1; dev_in_valid = 1; dev_in_data = 16'(i);
      tick();
      chk("wrap count", in_count, 1);
    end
    chk("wrap last", cpu_data_in, 16'h000A);

    // Output handshake
    do_reset();
    dev_out_ready = 0;
    cpu_wr = 1; cpu_data_out = 16'hBEEF; tick();
    chk("out valid", dev_out_valid, 1);
    chk("out busy", cpu_wr_busy, 1);
    chk("out data", dev_out_data, 16'hBEEF);
    cpu_wr = 1; cpu_data_out = 16'hCAFE; tick();
    chk("drop err", err, 2'b10);
    chk("drop data", dev_out_data, 16'hBEEF);
    dev_out_ready = 1;
    cpu_wr = 1; cpu_data_out = 16'h1234; tick();
    chk("replace data", dev_out_data, 16'h1234);
    chk("replace valid", dev_out_valid, 1);
    chk("replace busy", cpu_wr_busy, 0);
    tick();
    chk("drain valid", dev_out_valid, 0);

    // Interrupt episode
`ifdef PROC_IO_INT_EN
    exp_irq = 1;
`else
    exp_irq = 0;
`endif
    do_reset();
    push(16'hA001);
    chk("irq one word", interrupt, 0);
    push(16'hA002);
    chk("irq same edge", interrupt, 0);
    tick();
    chk("irq raised", interrupt, exp_irq);
    int_ack = 1; tick();
    chk("irq acked", interrupt, 0);
    push(16'hA003);
    tick();
    chk("irq third push", interrupt, 0);
    rd(); rd();
    chk("irq drained count", in_count, 1);
    chk("irq drained head", cpu_data_in, 16'hA003);
    push(16'hA004);
    tick();
    chk("irq rearmed", interrupt, exp_irq);

    // Random traffic with occasional mid-run resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      dev_in_valid = ($urandom_range(0, 99) < 55);
      dev_in_data  = 16'($urandom);
      cpu_rd       = ($urandom_range(0, 99) < 40);
      cpu_wr       = ($urandom_range(0, 99) < 30);
      cpu_data_out = 16'($urandom);
      dev_out_ready = ($urandom_range(0, 99) < 50);
      int_ack      = ($urandom_range(0, 99) < 15);
      reset        = ($urandom_range(0, 299) != 0);
      @(posedge clk);
      #1;
      reset = 1;
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
